rob_commit: RTL and testbench
=============================

Name: rob_commit

Overview:
- Reorder buffer feeding the architectural-state block.
- Allocates one in-order entry per renamed instruction and records completion from execute.
- Retires at most one entry per cycle, strictly in program order.
- At retirement, drives the register-clear interface (frees the stale physical register) and the flag-write interface (value plus keep-mask) of the architectural state.

Parameters:
ROB_DEPTH, 16, number of entries; power of two, >=2
NUM_PHYS_REG, 128, physical registers; tag width $clog2(NUM_PHYS_REG)
NUM_FLAGS, 4, architectural condition flags

Ports:
clk_i  in  1  clock, all state on rising edge
reset_i  in  1  asynchronous, active-low reset
flush_i  in  1  discard all entries
alloc_v_i  in  1  rename presents an instruction
alloc_ready_o  out  1  entry available
alloc_has_dest_i  in  1  instruction overwrites a register mapping
alloc_old_phys_i  in  $clog2(NUM_PHYS_REG)  stale physical reg to free at commit
alloc_tag_o  out  $clog2(ROB_DEPTH)  index given to the accepted instruction
cmp_v_i  in  1  execute completion
cmp_tag_i  in  $clog2(ROB_DEPTH)  completing entry
cmp_flag_v_i  in  1  instruction writes flags
cmp_flag_i  in  NUM_FLAGS*2  {keep_mask, value}; mask bit 1 = keep old flag
rob_phys_valid_o  out  1  free rob_phys_reg_cl_o this cycle
rob_phys_reg_cl_o  out  $clog2(NUM_PHYS_REG)  register to clear
rob_flag_valid_o  out  1  apply rob_flag_o
rob_flag_o  out  NUM_FLAGS*2  {keep_mask, value}
commit_v_o  out  1  one entry retired
count_o  out  $clog2(ROB_DEPTH)+1  occupied entries

Behaviour:
- Storage: circular buffer.
  - head and tail pointers are $clog2(ROB_DEPTH)+1 bits; the MSB is the wrap bit.
  - Empty when head==tail. Full when indices are equal and wrap bits differ.
  - Each entry holds: busy, done, has_dest, old_phys, flag_v, flag.
- Reset (reset_i low, asynchronous): head=tail=0; all busy/done=0; every output register 0. After reset, alloc_ready_o=1, alloc_tag_o=0, count_o=0.
- Allocate (alloc_v_i & alloc_ready_o at the edge):
  - Write the entry at tail with busy=1, done=0.
  - Increment tail.
  - alloc_tag_o always equals the current tail index (combinational).
- Backpressure: alloc_ready_o = ~full.
  - It does not account for a same-cycle commit.
  - A full ROB therefore accepts its next allocation one cycle after a retirement.
- Complete (cmp_v_i): if entry cmp_tag_i is busy, set done=1 and store flag_v/flag. If the entry is not busy, ignore the completion with no state change.
- Commit decision: made when the head entry is busy & done at a rising edge.
  - Clear the entry's busy and increment head.
  - Register the outputs for the following cycle:
    - commit_v_o=1.
    - rob_phys_valid_o=has_dest, rob_phys_reg_cl_o=old_phys.
    - rob_flag_valid_o=flag_v, rob_flag_o=flag.
  - In all other cycles, the valid outputs are 0. Data outputs hold their last value.
- Latency: a completion sampled at edge N can cause commit outputs in the cycle after edge N+1. Minimum one dead cycle between complete and retire.
- Throughput: at most 1 commit per cycle. Back-to-back commits are allowed when consecutive heads are done.
- Simultaneous events:
  - Alloc + commit in the same cycle: both take effect, count unchanged.
  - Complete of the head entry in the same cycle as a commit evaluation: not visible until the next edge.
  - Completion of an entry being allocated that same cycle: ignored (not yet busy).
- Flush (synchronous, highest priority):
  - head=tail=0, all busy=0.
  - Alloc, complete and commit in that cycle are dropped.
  - All valid outputs are 0 in the next cycle.
- Wrap-around: indices wrap modulo ROB_DEPTH and the wrap bit toggles. Full/empty are decided solely from pointer comparison.
- count_o = tail - head, with width $clog2(ROB_DEPTH)+1.

Test Plan:
- Reset then idle: assert reset_i low mid-run -> all outputs 0 immediately, alloc_ready_o=1, count_o=0.
- Basic retire: allocate tag 0 with has_dest=1, old_phys=17, then complete tag 0 with flag_v=1, cmp_flag_i={4'b1100,4'b0011} -> two cycles later a single pulse: commit_v_o=1, rob_phys_valid_o=1, rob_phys_reg_cl_o=17, rob_flag_o=8'hC3.
- Out-of-order completion: allocate tags 0,1,2; complete 2, then 1, then 0 -> commits in order 0,1,2 on three consecutive cycles, each starting only after tag 0 is done.
- Full/wrap: allocate 16 entries -> alloc_ready_o=0, count_o=16. Retire one -> ready returns the next cycle and alloc_tag_o=0 with the wrap bit toggled. Cycle 40 instructions through with no lost or duplicated commits.
- Flush: 5 busy entries, 3 done, assert flush_i -> no commit_v_o pulses afterwards, count_o=0, next alloc_tag_o=0.
- Stray completion: cmp_v_i to a non-busy tag -> no commit and no state change. An entry with has_dest=0 and flag_v=0 retires with commit_v_o=1 and both valid outputs 0.

Source files
------------

// File: rtl/rob_commit.sv
// In-order reorder buffer: allocates at tail, records out-of-order completion,
// retires one busy+done head entry per cycle into the architectural-state interfaces.
module rob_commit #(
  parameter int ROB_DEPTH    = 16,
  parameter int NUM_PHYS_REG = 128,
  parameter int NUM_FLAGS    = 4
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              flush_i,
  input  logic                              alloc_v_i,
  output logic                              alloc_ready_o,
  input  logic                              alloc_has_dest_i,
  input  logic [$clog2(NUM_PHYS_REG)-1:0]   alloc_old_phys_i,
  output logic [$clog2(ROB_DEPTH)-1:0]      alloc_tag_o,
  input  logic                              cmp_v_i,
  input  logic [$clog2(ROB_DEPTH)-1:0]      cmp_tag_i,
  input  logic                              cmp_flag_v_i,
  input  logic [NUM_FLAGS*2-1:0]            cmp_flag_i,
  output logic                              rob_phys_valid_o,
  output logic [$clog2(NUM_PHYS_REG)-1:0]   rob_phys_reg_cl_o,
  output logic                              rob_flag_valid_o,
  output logic [NUM_FLAGS*2-1:0]            rob_flag_o,
  output logic                              commit_v_o,
  output logic [$clog2(ROB_DEPTH):0]        count_o
);

  localparam int IW = $clog2(ROB_DEPTH);
  localparam int PW = $clog2(NUM_PHYS_REG);
  localparam int FW = NUM_FLAGS * 2;
  localparam logic [IW:0] PTR_ONE = {{IW{1'b0}}, 1'b1};

  logic [IW:0]          r_head;
  logic [IW:0]          r_tail;
  logic [ROB_DEPTH-1:0] r_busy;
  logic [ROB_DEPTH-1:0] r_done;
  logic [ROB_DEPTH-1:0] r_has_dest;
  logic [ROB_DEPTH-1:0] r_flag_v;
  logic [PW-1:0]        r_old_phys [ROB_DEPTH];
  logic [FW-1:0]        r_flag     [ROB_DEPTH];

  logic          r_commit_v;
  logic          r_phys_valid;
  logic [PW-1:0] r_phys_reg;
  logic          r_flag_valid;
  logic [FW-1:0] r_flag_out;

  logic          w_full;
  logic          w_alloc;
  logic          w_cmp;
  logic          w_commit;
  logic [IW-1:0] w_head_idx;
  logic [IW-1:0] w_tail_idx;

  // Pointer decode and per-cycle event qualification; flush suppresses every event.
  always_comb begin
    w_head_idx = r_head[IW-1:0];
    w_tail_idx = r_tail[IW-1:0];
    w_full     = (w_head_idx == w_tail_idx) && (r_head[IW] != r_tail[IW]);
    if (flush_i) begin
      w_alloc  = 1'b0;
      w_cmp    = 1'b0;
      w_commit = 1'b0;
    end else begin
      w_alloc  = alloc_v_i & ~w_full;
      w_cmp    = cmp_v_i & r_busy[cmp_tag_i];
      w_commit = r_busy[w_head_idx] & r_done[w_head_idx];
    end
  end

  assign alloc_ready_o     = ~w_full;
  assign alloc_tag_o       = w_tail_idx;
  assign count_o           = r_tail - r_head;
  assign commit_v_o        = r_commit_v;
  assign rob_phys_valid_o  = r_phys_valid;
  assign rob_phys_reg_cl_o = r_phys_reg;
  assign rob_flag_valid_o  = r_flag_valid;
  assign rob_flag_o        = r_flag_out;

  // Head/tail pointers with wrap bit.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (flush_i) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_alloc) begin
        r_tail <= r_tail + PTR_ONE;
      end
      if (w_commit) begin
        r_head <= r_head + PTR_ONE;
      end
    end
  end

  // Entry storage. A completion can only hit a busy entry, so it never collides
  // with the allocation slot (tail is busy only when full, which blocks allocation).
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_busy     <= '0;
      r_done     <= '0;
      r_has_dest <= '0;
      r_flag_v   <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        r_old_phys[i] <= '0;
        r_flag[i]     <= '0;
      end
    end else if (flush_i) begin
      r_busy <= '0;
    end else begin
      if (w_cmp) begin
        r_done[cmp_tag_i]   <= 1'b1;
        r_flag_v[cmp_tag_i] <= cmp_flag_v_i;
        r_flag[cmp_tag_i]   <= cmp_flag_i;
      end
      if (w_commit) begin
        r_busy[w_head_idx] <= 1'b0;
      end
      if (w_alloc) begin
        r_busy[w_tail_idx]     <= 1'b1;
        r_done[w_tail_idx]     <= 1'b0;
        r_has_dest[w_tail_idx] <= alloc_has_dest_i;
        r_old_phys[w_tail_idx] <= alloc_old_phys_i;
      end
    end
  end

  // Registered retirement outputs; data fields hold between commits.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_commit_v   <= 1'b0;
      r_phys_valid <= 1'b0;
      r_phys_reg   <= '0;
      r_flag_valid <= 1'b0;
      r_flag_out   <= '0;
    end else if (w_commit) begin
      r_commit_v   <= 1'b1;
      r_phys_valid <= r_has_dest[w_head_idx];
      r_phys_reg   <= r_old_phys[w_head_idx];
      r_flag_valid <= r_flag_v[w_head_idx];
      r_flag_out   <= r_flag[w_head_idx];
    end else begin
      r_commit_v   <= 1'b0;
      r_phys_valid <= 1'b0;
      r_flag_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// Self-checking bench for rob_commit: directed scenarios plus random traffic,
// compared each cycle against a queue-based model of the in-order buffer.
module tb_rob_commit;

  localparam int D = 16;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       flush_i;
  logic       alloc_v_i;
  logic       alloc_ready_o;
  logic       alloc_has_dest_i;
  logic [6:0] alloc_old_phys_i;
  logic [3:0] alloc_tag_o;
  logic       cmp_v_i;
  logic [3:0] cmp_tag_i;
  logic       cmp_flag_v_i;
  logic [7:0] cmp_flag_i;
  logic       rob_phys_valid_o;
  logic [6:0] rob_phys_reg_cl_o;
  logic       rob_flag_valid_o;
  logic [7:0] rob_flag_o;
  logic       commit_v_o;
  logic [4:0] count_o;

  rob_commit dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
    .alloc_v_i(alloc_v_i), .alloc_ready_o(alloc_ready_o),
    .alloc_has_dest_i(alloc_has_dest_i), .alloc_old_phys_i(alloc_old_phys_i),
    .alloc_tag_o(alloc_tag_o), .cmp_v_i(cmp_v_i), .cmp_tag_i(cmp_tag_i),
    .cmp_flag_v_i(cmp_flag_v_i), .cmp_flag_i(cmp_flag_i),
    .rob_phys_valid_o(rob_phys_valid_o), .rob_phys_reg_cl_o(rob_phys_reg_cl_o),
    .rob_flag_valid_o(rob_flag_valid_o), .rob_flag_o(rob_flag_o),
    .commit_v_o(commit_v_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0] tag;
    logic       has_dest;
    logic [6:0] old_phys;
    logic       done;
    logic       flag_v;
    logic [7:0] flag;
  } ent_t;

  ent_t q[$];
  int   m_tail;
  logic e_commit, e_pv, e_fv;
  logic [6:0] e_preg;
  logic [7:0] e_flag;
  int   total = 0;
  int   bad = 0;
  int   n_commits = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_tail = 0;
    e_commit = 1'b0; e_pv = 1'b0; e_fv = 1'b0;
    e_preg = 7'd0; e_flag = 8'd0;
  endtask

  task automatic check_all();
    chk("commit_v", {31'd0, commit_v_o}, {31'd0, e_commit});
    chk("phys_v", {31'd0, rob_phys_valid_o}, {31'd0, e_pv});
    chk("phys_reg", {25'd0, rob_phys_reg_cl_o}, {25'd0, e_preg});
    chk("flag_v", {31'd0, rob_flag_valid_o}, {31'd0, e_fv});
    chk("flag", {24'd0, rob_flag_o}, {24'd0, e_flag});
    chk("ready", {31'd0, alloc_ready_o}, (q.size() < D) ? 32'd1 : 32'd0);
    chk("count", {27'd0, count_o}, q.size());
    chk("tag", {28'd0, alloc_tag_o}, m_tail % D);
  endtask

  // One clock: drive inputs, advance the model at the edge, check just after it.
  task automatic step(input logic a_v, input logic a_hd, input logic [6:0] a_op,
                      input logic c_v, input logic [3:0] c_tag, input logic c_fv,
                      input logic [7:0] c_fl, input logic fl);
    int   sz0;
    logic do_commit;
    ent_t front;
    alloc_v_i = a_v; alloc_has_dest_i = a_hd; alloc_old_phys_i = a_op;
    cmp_v_i = c_v; cmp_tag_i = c_tag; cmp_flag_v_i = c_fv; cmp_flag_i = c_fl;
    flush_i = fl;
    @(posedge clk_i);
    if (fl) begin
      q.delete();
      m_tail = 0;
      e_commit = 1'b0; e_pv = 1'b0; e_fv = 1'b0;
    end else begin
      sz0 = q.size();
      do_commit = (sz0 > 0) && q[0].done;
      if (sz0 > 0) front = q[0];
      if (c_v) begin
        for (int i = 0; i < q.size(); i++) begin
          if (q[i].tag == c_tag) begin
            q[i].done = 1'b1; q[i].flag_v = c_fv; q[i].flag = c_fl;
          end
        end
      end
      if (do_commit) begin
        e_commit = 1'b1; e_pv = front.has_dest; e_preg = front.old_phys;
        e_fv = front.flag_v; e_flag = front.flag;
        void'(q.pop_front());
        n_commits++;
      end else begin
        e_commit = 1'b0; e_pv = 1'b0; e_fv = 1'b0;
      end
      if (a_v && sz0 < D) begin
        q.push_back('{tag: 4'(m_tail % D), has_dest: a_hd, old_phys: a_op,
                      done: 1'b0, flag_v: 1'b0, flag: 8'd0});
        m_tail = (m_tail + 1) % (2 * D);
      end
    end
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 7'd0, 1'b0, 4'd0, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic alloc(input logic hd, input logic [6:0] op);
    step(1'b1, hd, op, 1'b0, 4'd0, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic cmp(input logic [3:0] t, input logic fv, input logic [7:0] fl);
    step(1'b0, 1'b0, 7'd0, 1'b1, t, fv, fl, 1'b0);
  endtask

  // Asynchronous reset asserted away from the edge; outputs must clear at once.
  task automatic do_reset();
    reset_i = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_ready", {31'd0, alloc_ready_o}, 32'd1);
    chk("rst_count", {27'd0, count_o}, 32'd0);
    @(negedge clk_i);
    reset_i = 1'b1;
  endtask

  initial begin
    logic a_v, c_v, fl;
    logic [3:0] ct;
    int pa, pc;
    reset_i = 1'b0; flush_i = 1'b0; alloc_v_i = 1'b0; alloc_has_dest_i = 1'b0;
    alloc_old_phys_i = 7'd0; cmp_v_i = 1'b0; cmp_tag_i = 4'd0;
    cmp_flag_v_i = 1'b0; cmp_flag_i = 8'd0;
    model_reset();
    #12;
    check_all();
    @(negedge clk_i);
    reset_i = 1'b1;

    // Basic retire
    alloc(1'b1, 7'd17);
    cmp(4'd0, 1'b1, {4'b1100, 4'b0011});
    idle(1);
    chk("basic_commit", {31'd0, commit_v_o}, 32'd1);
    chk("basic_phys", {25'd0, rob_phys_reg_cl_o}, 32'd17);
    chk("basic_flag", {24'd0, rob_flag_o}, 32'hC3);
    idle(1);
    chk("basic_pulse", {31'd0, commit_v_o}, 32'd0);

    // Out-of-order completion, in-order retirement
    alloc(1'b1, 7'd10); alloc(1'b1, 7'd11); alloc(1'b1, 7'd12);
    cmp(4'd3, 1'b0, 8'h00); cmp(4'd2, 1'b1, 8'h5A);
    idle(2);
    chk("ooo_wait", {31'd0, commit_v_o}, 32'd0);
    cmp(4'd1, 1'b0, 8'h00);
    idle(1);
    chk("ooo_c0", {25'd0, rob_phys_reg_cl_o}, 32'd10);
    idle(1);
    chk("ooo_c1", {25'd0, rob_phys_reg_cl_o}, 32'd11);
    idle(1);
    chk("ooo_c2", {25'd0, rob_phys_reg_cl_o}, 32'd12);
    idle(2);

    // Full and wrap
    do_reset();
    for (int i = 0; i < D; i++) alloc(1'b1, 7'(i + 40));
    chk("full_ready", {31'd0, alloc_ready_o}, 32'd0);
    chk("full_count", {27'd0, count_o}, 32'd16);
    alloc(1'b1, 7'd99);
    cmp(4'd0, 1'b0, 8'h00);
    alloc(1'b1, 7'd98);
    chk("wrap_ready", {31'd0, alloc_ready_o}, 32'd1);
    chk("wrap_tag", {28'd0, alloc_tag_o}, 32'd0);
    alloc(1'b1, 7'd97);
    chk("wrap_refill", {31'd0, alloc_ready_o}, 32'd0);

    // Flush with partially completed entries
    do_reset();
    for (int i = 0; i < 5; i++) alloc(1'b1, 7'(i + 1));
    cmp(4'd1, 1'b0, 8'h00); cmp(4'd2, 1'b0, 8'h00); cmp(4'd3, 1'b0, 8'h00);
    step(1'b1, 1'b1, 7'd9, 1'b1, 4'd0, 1'b0, 8'h00, 1'b1);
    chk("flush_count", {27'd0, count_o}, 32'd0);
    chk("flush_tag", {28'd0, alloc_tag_o}, 32'd0);
    idle(4);

    // Stray completion, then a retirement with no register or flag update
    cmp(4'd5, 1'b1, 8'hFF);
    idle(2);
    alloc(1'b0, 7'd3);
    cmp(4'd0, 1'b0, 8'h00);
    idle(1);
    chk("plain_commit", {31'd0, commit_v_o}, 32'd1);
    chk("plain_pv", {31'd0, rob_phys_valid_o}, 32'd0);
    chk("plain_fv", {31'd0, rob_flag_valid_o}, 32'd0);

    // Random traffic in phases of varying alloc/complete pressure
    n_commits = 0;
    for (int ph = 0; ph < 12; ph++) begin
      pa = $urandom_range(20, 95);
      pc = $urandom_range(20, 95);
      if (ph == 6) do_reset();
      for (int c = 0; c < 80; c++) begin
        a_v = ($urandom_range(0, 99) < pa);
        c_v = ($urandom_range(0, 99) < pc);
        if (q.size() > 0 && $urandom_range(0, 3) != 0)
          ct = q[$urandom_range(0, q.size() - 1)].tag;
        else
          ct = 4'($urandom_range(0, 15));
        fl = ($urandom_range(0, 99) == 0);
        step(a_v, 1'($urandom), 7'($urandom), c_v, ct, 1'($urandom), 8'($urandom), fl);
      end
    end
    chk("rand_progress", (n_commits >= 40) ? 32'd1 : 32'd0, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
